// File: rtl/gonso_pixel_streamer.sv
// rtl/gonso_pixel_streamer.sv - pixel FIFO and channel serialiser onto a strobed colour bus
// Optional frame CRC over emitted words when GONSO_STREAM_CRC_EN is defined.
module gonso_pixel_streamer #(
  parameter int WIDTH      = 64,
  parameter int HEIGHT     = 64,
  parameter int COLOR_W    = 8,
  parameter int CHANNELS   = 3,
  parameter int FIFO_DEPTH = 4,
  parameter int STROBE_GAP = 0
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_i,
  input  logic                        start,
  input  logic                        pix_valid,
  input  logic [COLOR_W*CHANNELS-1:0] pix_data,
  output logic                        pix_ready,
  output logic [COLOR_W-1:0]          color,
  output logic                        pixel_write,
  output logic                        line_end,
  output logic                        frame_done,
  output logic                        busy,
  output logic [15:0]                 status,
  output logic [15:0]                 frame_crc
);
  localparam int PIX_W = COLOR_W * CHANNELS;
  localparam int TOTAL = WIDTH * HEIGHT;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int XW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int YW    = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int CW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int NW    = $clog2(TOTAL + 1);
`ifdef GONSO_STREAM_CRC_EN
  localparam logic [15:0] STATUS_POST = 16'hAB63;
`else
  localparam logic [15:0] STATUS_POST = 16'hAB62;
`endif

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DONE} state_e;
  state_e state_q, state_d;

  logic [PIX_W-1:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]        count_q, count_d;
  logic [XW-1:0]      x_q, x_d;
  logic [YW-1:0]      y_q, y_d;
  logic [CW-1:0]      ch_q, ch_d;
  logic [NW-1:0]      acc_q, acc_d;
  logic [3:0]         gap_q, gap_d;
  logic [COLOR_W-1:0] color_q, color_d;
  logic               done_q, done_d;

  logic               fifo_full, fifo_empty, push, pop, emit;
  logic               last_ch, last_x, last_y;
  logic [PIX_W-1:0]   head;
  logic [COLOR_W-1:0] head_word;

  always_comb begin
    fifo_full  = (count_q == (AW+1)'(FIFO_DEPTH));
    fifo_empty = (count_q == '0);
    head       = mem_q[rd_ptr_q];
    head_word  = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (ch_q == CW'(k)) head_word = head[k*COLOR_W +: COLOR_W];
    end
    last_ch = (ch_q == CW'(CHANNELS - 1));
    last_x  = (x_q == XW'(WIDTH - 1));
    last_y  = (y_q == YW'(HEIGHT - 1));

    busy        = (state_q == S_STREAM);
    frame_done  = (state_q == S_DONE);
    pix_ready   = busy && !fifo_full && (acc_q < NW'(TOTAL));
    push        = pix_valid && pix_ready;
    emit        = busy && !fifo_empty && (gap_q == 4'd0);
    pop         = emit && last_ch;
    pixel_write = emit;
    color       = emit ? head_word : color_q;
    line_end    = emit && last_ch && last_x;

    case (state_q)
      S_STREAM: status = 16'hAB61;
      S_DONE:   status = 16'hAB62;
      default:  status = done_q ? STATUS_POST : 16'hAB60;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    x_d      = x_q;
    y_d      = y_q;
    ch_d     = ch_q;
    acc_d    = acc_q;
    gap_d    = gap_q;
    color_d  = color_q;
    done_d   = done_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      acc_d    = acc_q + NW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase

    if (emit) begin
      color_d = head_word;
      gap_d   = 4'(STROBE_GAP);
      if (last_ch) begin
        ch_d = '0;
        if (last_x) begin
          x_d = '0;
          y_d = last_y ? '0 : y_q + YW'(1);
        end else begin
          x_d = x_q + XW'(1);
        end
      end else begin
        ch_d = ch_q + CW'(1);
      end
    end else if (gap_q != 4'd0) begin
      gap_d = gap_q - 4'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_STREAM;
          x_d     = '0;
          y_d     = '0;
          ch_d    = '0;
          acc_d   = '0;
          gap_d   = '0;
          done_d  = 1'b0;
        end
      end
      S_STREAM: if (emit && last_ch && last_x && last_y) state_d = S_DONE;
      S_DONE: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      x_q      <= '0;
      y_q      <= '0;
      ch_q     <= '0;
      acc_q    <= '0;
      gap_q    <= '0;
      color_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      x_q      <= x_d;
      y_q      <= y_d;
      ch_q     <= ch_d;
      acc_q    <= acc_d;
      gap_q    <= gap_d;
      color_q  <= color_d;
      done_q   <= done_d;
    end
  end

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge wb_clk_i) begin
    if (push) mem_q[wr_ptr_q] <= pix_data;
  end

`ifdef GONSO_STREAM_CRC_EN
  localparam int EXT_W = (COLOR_W > 8) ? COLOR_W : 8;

  function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in, input logic [7:0] data);
    logic [15:0] c;
    c = crc_in;
    for (int i = 7; i >= 0; i--) begin
      c = (c[15] ^ data[i]) ? ({c[14:0], 1'b0} ^ 16'h1021) : {c[14:0], 1'b0};
    end
    return c;
  endfunction

  logic [15:0]      crc_q, crc_d, frame_crc_q, frame_crc_d;
  logic [EXT_W-1:0] crc_word;

  always_comb begin
    crc_word    = EXT_W'(head_word);
    crc_d       = crc_q;
    frame_crc_d = frame_crc_q;
    if (state_q == S_IDLE && start) crc_d = 16'hFFFF;
    else if (emit) crc_d = crc16_byte(crc_q, crc_word[7:0]);
    if (state_q == S_DONE) frame_crc_d = crc_q;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      crc_q       <= 16'hFFFF;
      frame_crc_q <= 16'h0000;
    end else begin
      crc_q       <= crc_d;
      frame_crc_q <= frame_crc_d;
    end
  end

  assign frame_crc = frame_crc_q;
`else
  assign frame_crc = 16'h0000;
`endif
endmodule

// File: tb/tb_gonso_pixel_streamer.sv
// tb/tb_gonso_pixel_streamer.sv - randomized self-checking bench for gonso_pixel_streamer
// Three instances: 4x2 RGB gap 0, 4x2 RGB gap 2, 1x1 grey for the frame CRC.
module tb_gonso_pixel_streamer;
  localparam int W = 4, H = 2, CH = 3, NPIX = W * H, NWORD = NPIX * CH;
`ifdef GONSO_STREAM_CRC_EN
  localparam bit CRC_ON = 1'b1;
`else
  localparam bit CRC_ON = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int tests = 0, fails = 0;

  logic rst0 = 1, start0 = 0, valid0 = 0, ready0, pw0, le0, fd0, busy0;
  logic [23:0] data0 = '0;
  logic [7:0] color0;
  logic [15:0] status0, crc0;
  logic rst1 = 1, start1 = 0, valid1 = 0, ready1, pw1, le1, fd1, busy1;
  logic [23:0] data1 = '0;
  logic [7:0] color1;
  logic [15:0] status1, crc1;
  logic rst2 = 1, start2 = 0, valid2 = 0, ready2, pw2, le2, fd2, busy2;
  logic [7:0] data2 = '0, color2;
  logic [15:0] status2, crc2;

  gonso_pixel_streamer #(.WIDTH(W), .HEIGHT(H), .COLOR_W(8), .CHANNELS(CH), .FIFO_DEPTH(4), .STROBE_GAP(0)) dut0 (
    .wb_clk_i(clk), .wb_rst_i(rst0), .start(start0), .pix_valid(valid0), .pix_data(data0),
    .pix_ready(ready0), .color(color0), .pixel_write(pw0), .line_end(le0), .frame_done(fd0),
    .busy(busy0), .status(status0), .frame_crc(crc0));
  gonso_pixel_streamer #(.WIDTH(W), .HEIGHT(H), .COLOR_W(8), .CHANNELS(CH), .FIFO_DEPTH(4), .STROBE_GAP(2)) dut1 (
    .wb_clk_i(clk), .wb_rst_i(rst1), .start(start1), .pix_valid(valid1), .pix_data(data1),
    .pix_ready(ready1), .color(color1), .pixel_write(pw1), .line_end(le1), .frame_done(fd1),
    .busy(busy1), .status(status1), .frame_crc(crc1));
  gonso_pixel_streamer #(.WIDTH(1), .HEIGHT(1), .COLOR_W(8), .CHANNELS(1), .FIFO_DEPTH(2), .STROBE_GAP(0)) dut2 (
    .wb_clk_i(clk), .wb_rst_i(rst2), .start(start2), .pix_valid(valid2), .pix_data(data2),
    .pix_ready(ready2), .color(color2), .pixel_write(pw2), .line_end(le2), .frame_done(fd2),
    .busy(busy2), .status(status2), .frame_crc(crc2));

  logic [7:0] obs_w[$], obs1_w[$];
  bit obs_le[$], obs1_le[$];
  int obs_t[$], obs1_t[$], fd_t[$], fd1_t[$];
  always @(negedge clk) begin
    if (pw0) begin obs_w.push_back(color0); obs_le.push_back(le0); obs_t.push_back(cyc); end
    if (fd0) fd_t.push_back(cyc);
    if (pw1) begin obs1_w.push_back(color1); obs1_le.push_back(le1); obs1_t.push_back(cyc); end
    if (fd1) fd1_t.push_back(cyc);
  end

  logic [23:0] pix[NPIX];
  logic [7:0] exp_w[NWORD];

  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {b, 8'h00};
    for (int i = 0; i < 8; i++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    return r;
  endfunction

  task automatic gen_pix(input bit rnd);
    logic [23:0] p;
    for (int i = 0; i < NPIX; i++) begin
      pix[i] = rnd ? 24'($urandom) : {8'(3*i+2), 8'(3*i+1), 8'(3*i)};
      p = pix[i];
      for (int k = 0; k < CH; k++) exp_w[i*CH+k] = p[k*8 +: 8];
    end
  endtask

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  // Drives one frame into dut0 and checks the emitted word stream against exp_w.
  task automatic run0(input string name, input int stall_after, input int stall_len, input bit rand_valid,
                      input bit extra, input int midstart, input int rst_word);
    int sent = 0, stall = 0, n = 0, first_dec = -1, bad_stat = 0;
    logic [15:0] ecrc;
    obs_w.delete(); obs_le.delete(); obs_t.delete(); fd_t.delete();
    start0 = 1; tick(); start0 = 0;
    while (fd_t.size() == 0) begin
      if (n > 2000) begin
        tests++; fails++; $display("FAIL %s timeout: no frame_done after %0d cycles", name, n);
        break;
      end
      if (status0 !== 16'hAB61 || busy0 !== 1'b1) bad_stat++;
      if (rst_word >= 0 && obs_w.size() > rst_word) begin
        rst0 = 1; valid0 = 0; start0 = 0; tick(); rst0 = 0;
        return;
      end
      start0 = (n == midstart);
      if (stall_after >= 0 && sent == stall_after + 1 && stall < stall_len) begin
        valid0 = 0; stall++;
        if (stall > 13) begin
          tests++; if (pw0 !== 1'b0) begin fails++; $display("FAIL %s stall_pw: got %b want 0", name, pw0); end
        end
        if (stall == stall_len) begin
          tests++;
          if (obs_w.size() !== (stall_after + 1) * CH) begin
            fails++; $display("FAIL %s drained: got %0d words want %0d", name, obs_w.size(), (stall_after + 1) * CH);
          end
        end
      end else if (sent < NPIX) begin
        valid0 = rand_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
        data0 = pix[sent];
        if (valid0 && ready0) begin
          if (sent == 0) first_dec = cyc;
          sent++;
        end
      end else begin
        valid0 = extra; data0 = 24'hFFFFFF;
        if (extra) begin
          tests++; if (ready0 !== 1'b0) begin fails++; $display("FAIL %s ninth_ready: got %b want 0", name, ready0); end
        end
      end
      tick(); n++;
    end
    valid0 = 0; start0 = 0;
    tests++; if (bad_stat != 0) begin fails++; $display("FAIL %s stream_status: %0d cycles not AB61/busy, want 0", name, bad_stat); end
    tests++; if (status0 !== 16'hAB62) begin fails++; $display("FAIL %s done_status: got %h want AB62", name, status0); end
    tests++; if (obs_w.size() !== NWORD) begin fails++; $display("FAIL %s word_count: got %0d want %0d", name, obs_w.size(), NWORD); end
    for (int k = 0; k < obs_w.size() && k < NWORD; k++) begin
      tests++;
      if (obs_w[k] !== exp_w[k] || obs_le[k] !== ((k + 1) % (W * CH) == 0)) begin
        fails++; $display("FAIL %s word[%0d]: got %h le=%b want %h le=%b", name, k, obs_w[k], obs_le[k], exp_w[k], ((k + 1) % (W * CH) == 0));
      end
    end
    if (obs_t.size() > 0) begin
      tests++; if (obs_t[0] !== first_dec + 1) begin fails++; $display("FAIL %s latency: got cycle %0d want %0d", name, obs_t[0], first_dec + 1); end
      tests++; if (fd_t.size() > 0 && fd_t[0] !== obs_t[obs_t.size()-1] + 1) begin
        fails++; $display("FAIL %s done_time: got %0d want %0d", name, fd_t[0], obs_t[obs_t.size()-1] + 1);
      end
    end
    if (!rand_valid && stall_after < 0 && obs_t.size() == NWORD) begin
      tests++; if (obs_t[NWORD-1] - obs_t[0] !== NWORD - 1) begin
        fails++; $display("FAIL %s back_to_back: span %0d want %0d", name, obs_t[NWORD-1] - obs_t[0], NWORD - 1);
      end
    end
    tick();
    ecrc = 16'hFFFF;
    for (int k = 0; k < NWORD; k++) ecrc = crc_byte(ecrc, exp_w[k]);
    if (!CRC_ON) ecrc = 16'h0000;
    tests++; if (status0 !== (CRC_ON ? 16'hAB63 : 16'hAB62) || busy0 !== 1'b0 || fd_t.size() != 1) begin
      fails++; $display("FAIL %s post_status: got %h busy=%b dones=%0d want %h busy=0 dones=1", name, status0, busy0, fd_t.size(), CRC_ON ? 16'hAB63 : 16'hAB62);
    end
    tests++; if (crc0 !== ecrc) begin fails++; $display("FAIL %s frame_crc: got %h want %h", name, crc0, ecrc); end
  endtask

  task automatic test_reset;
    tick(); tick(); tick();
    tests++;
    if ({color0, pw0, le0, fd0, busy0, ready0, status0, crc0} !== {8'h00, 5'b0, 16'hAB60, 16'h0000}) begin
      fails++; $display("FAIL reset_values: got %h/%b%b%b%b%b/%h/%h want 00/00000/AB60/0000", color0, pw0, le0, fd0, busy0, ready0, status0, crc0);
    end
    rst0 = 0; rst1 = 0; rst2 = 0;
    valid0 = 1; data0 = 24'h123456;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++; if (ready0 !== 1'b0 || pw0 !== 1'b0 || status0 !== 16'hAB60) begin
        fails++; $display("FAIL idle_ignore: got ready=%b pw=%b status=%h want 0/0/AB60", ready0, pw0, status0);
      end
    end
    valid0 = 0;
  endtask

  task automatic test_frame;
    gen_pix(0); run0("pattern", -1, 0, 0, 0, -1, -1);
    gen_pix(1); run0("random", -1, 0, 1, 0, -1, -1);
  endtask

  task automatic test_stall;
    gen_pix(0); run0("stall", 3, 20, 0, 0, -1, -1);
  endtask

  task automatic test_extra_start;
    gen_pix(1); run0("extra_start", -1, 0, 0, 1, 10, -1);
  endtask

  task automatic test_reset_midframe;
    gen_pix(0); run0("abort", -1, 0, 0, 0, -1, 10);
    tests++;
    if ({color0, pw0, le0, fd0, busy0, ready0, status0, crc0} !== {8'h00, 5'b0, 16'hAB60, 16'h0000}) begin
      fails++; $display("FAIL abort_values: got %h/%b%b%b%b%b/%h/%h want 00/00000/AB60/0000", color0, pw0, le0, fd0, busy0, ready0, status0, crc0);
    end
    tick(); tick(); tick();
    tests++; if (fd_t.size() != 0 || obs_w.size() != 11) begin
      fails++; $display("FAIL abort_quiet: got dones=%0d words=%0d want 0/11", fd_t.size(), obs_w.size());
    end
    gen_pix(0); run0("after_abort", -1, 0, 0, 0, -1, -1);
  endtask

  task automatic test_gap;
    int sent = 0, prev = 0, occ, maxocc = 0, n = 0;
    bit exp_rdy;
    gen_pix(1);
    obs1_w.delete(); obs1_le.delete(); obs1_t.delete(); fd1_t.delete();
    start1 = 1; tick(); start1 = 0;
    while (fd1_t.size() == 0 && n < 1000) begin
      occ = sent - prev / CH;
      exp_rdy = (occ < 4) && (sent < NPIX);
      if (occ > maxocc) maxocc = occ;
      tests++; if (ready1 !== exp_rdy) begin fails++; $display("FAIL gap_ready n=%0d: got %b want %b (occ %0d)", n, ready1, exp_rdy, occ); end
      valid1 = (sent < NPIX);
      data1 = pix[(sent < NPIX) ? sent : 0];
      if (valid1 && ready1) sent++;
      prev = obs1_w.size();
      tick(); n++;
    end
    valid1 = 0;
    tests++; if (fd1_t.size() != 1) begin fails++; $display("FAIL gap_done: got %0d dones want 1 (timeout)", fd1_t.size()); end
    tests++; if (maxocc !== 4) begin fails++; $display("FAIL gap_fill: got max occupancy %0d want 4", maxocc); end
    tests++; if (obs1_w.size() !== NWORD) begin fails++; $display("FAIL gap_count: got %0d want %0d", obs1_w.size(), NWORD); end
    for (int k = 0; k < obs1_w.size() && k < NWORD; k++) begin
      tests++;
      if (obs1_w[k] !== exp_w[k] || obs1_le[k] !== ((k + 1) % (W * CH) == 0) || (k > 0 && obs1_t[k] - obs1_t[k-1] !== 3)) begin
        fails++; $display("FAIL gap_word[%0d]: got %h le=%b spacing=%0d want %h le=%b spacing=3", k, obs1_w[k], obs1_le[k],
                          (k > 0) ? obs1_t[k] - obs1_t[k-1] : 3, exp_w[k], ((k + 1) % (W * CH) == 0));
      end
    end
    tick();
  endtask

  task automatic test_crc;
    logic [7:0] b;
    logic [15:0] ecrc;
    int n;
    for (int f = 0; f < 2; f++) begin
      b = (f == 0) ? 8'h00 : 8'($urandom);
      ecrc = CRC_ON ? crc_byte(16'hFFFF, b) : 16'h0000;
      if (f == 0 && CRC_ON) begin
        tests++; if (ecrc !== 16'hE1F0) begin fails++; $display("FAIL crc_model: got %h want E1F0", ecrc); end
      end
      start2 = 1; tick(); start2 = 0;
      n = 0;
      while (fd2 !== 1'b1 && n < 50) begin valid2 = 1; data2 = b; tick(); n++; end
      valid2 = 0;
      tests++; if (fd2 !== 1'b1 || status2 !== 16'hAB62) begin
        fails++; $display("FAIL crc_done f=%0d: got fd=%b status=%h want 1/AB62", f, fd2, status2);
      end
      tick();
      tests++; if (status2 !== (CRC_ON ? 16'hAB63 : 16'hAB62) || crc2 !== ecrc) begin
        fails++; $display("FAIL crc_result f=%0d: got %h/%h want %h/%h", f, status2, crc2, CRC_ON ? 16'hAB63 : 16'hAB62, ecrc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_stall();
    test_extra_start();
    test_reset_midframe();
    test_gap();
    test_crc();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
